// File: rtl/dm_arb.sv
// dm_arb: round-robin arbiter with a bounded lock that puts two requesters onto the single-ported data memory.
// Grants and memory drive are combinational. Completion acks and read data are registered.
`default_nettype none

module dm_arb #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int LockMax = 16
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          Req0,
    input  logic          We0,
    input  logic          Lock0,
    input  logic [AW-1:0] Adr0,
    input  logic [DW-1:0] Wdat0,
    output logic          Gnt0,
    output logic          Ack0,
    output logic [DW-1:0] Rdat0,
    input  logic          Req1,
    input  logic          We1,
    input  logic          Lock1,
    input  logic [AW-1:0] Adr1,
    input  logic [DW-1:0] Wdat1,
    output logic          Gnt1,
    output logic          Ack1,
    output logic [DW-1:0] Rdat1,
    output logic [AW-1:0] MemAdr,
    output logic          ReadEn,
    output logic          WriteEn,
    output logic [DW-1:0] DatIn,
    input  logic [DW-1:0] DatOut
);

    typedef enum logic [1:0] {
        ST_NONE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } own_t;

    localparam logic [7:0] c_lock_max = 8'(LockMax);

    own_t          r_owner;
    logic          r_ptr;
    logic [7:0]    r_lock_cnt;
    logic          r_ack0;
    logic          r_ack1;
    logic [DW-1:0] r_rdat0;
    logic [DW-1:0] r_rdat1;

    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_gnt_any;
    logic          w_we;
    logic          w_lock;
    logic [AW-1:0] w_adr;
    logic [DW-1:0] w_wdat;
    logic [7:0]    w_cnt_next;
    logic          w_cnt_hit;

    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!Reset) begin
            case (r_owner)
                ST_OWN0: w_gnt0 = Req0;
                ST_OWN1: w_gnt1 = Req1;
                default: begin
                    if (Req0 && Req1) begin
                        w_gnt0 = ~r_ptr;
                        w_gnt1 = r_ptr;
                    end else begin
                        w_gnt0 = Req0;
                        w_gnt1 = Req1;
                    end
                end
            endcase
        end
    end

    assign w_gnt_any = w_gnt0 | w_gnt1;
    assign w_we      = w_gnt1 ? We1   : We0;
    assign w_lock    = w_gnt1 ? Lock1 : Lock0;
    assign w_adr     = w_gnt1 ? Adr1  : Adr0;
    assign w_wdat    = w_gnt1 ? Wdat1 : Wdat0;

    // The counter idles at 0 when unowned, so +1 is the count including the current grant.
    // The lock breaks on the grant that brings this count up to LockMax.
    assign w_cnt_next = r_lock_cnt + 8'd1;
    assign w_cnt_hit  = (w_cnt_next >= c_lock_max);

    assign Gnt0    = w_gnt0;
    assign Gnt1    = w_gnt1;
    assign MemAdr  = w_gnt_any ? w_adr  : '0;
    assign DatIn   = w_gnt_any ? w_wdat : '0;
    assign WriteEn = w_gnt_any &  w_we;
    assign ReadEn  = w_gnt_any & ~w_we;

    // While Reset is high, any in-flight completion is hidden at once.
    assign Ack0  = r_ack0 & ~Reset;
    assign Ack1  = r_ack1 & ~Reset;
    assign Rdat0 = Reset ? '0 : r_rdat0;
    assign Rdat1 = Reset ? '0 : r_rdat1;

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_owner    <= ST_NONE;
            r_ptr      <= 1'b0;
            r_lock_cnt <= 8'd0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_rdat0    <= '0;
            r_rdat1    <= '0;
        end else begin
            r_ack0 <= w_gnt0;
            r_ack1 <= w_gnt1;
            if (w_gnt0 && !We0) begin
                r_rdat0 <= DatOut;
            end
            if (w_gnt1 && !We1) begin
                r_rdat1 <= DatOut;
            end
            case (r_owner)
                ST_NONE: begin
                    if (w_gnt_any) begin
                        if (w_lock && !w_cnt_hit) begin
                            r_owner    <= w_gnt1 ? ST_OWN1 : ST_OWN0;
                            r_lock_cnt <= w_cnt_next;
                        end else begin
                            r_ptr <= ~w_gnt1;
                        end
                    end
                end
                ST_OWN0: begin
                    if (!Lock0 || (w_gnt0 && w_cnt_hit)) begin
                        r_owner    <= ST_NONE;
                        r_lock_cnt <= 8'd0;
                        r_ptr      <= 1'b1;
                    end else if (w_gnt0) begin
                        r_lock_cnt <= w_cnt_next;
                    end
                end
                ST_OWN1: begin
                    if (!Lock1 || (w_gnt1 && w_cnt_hit)) begin
                        r_owner    <= ST_NONE;
                        r_lock_cnt <= 8'd0;
                        r_ptr      <= 1'b0;
                    end else if (w_gnt1) begin
                        r_lock_cnt <= w_cnt_next;
                    end
                end
                default: begin
                    r_owner    <= ST_NONE;
                    r_lock_cnt <= 8'd0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dm_arb.sv
// tb_dm_arb: directed testbench for dm_arb. It uses a behavioural dm and a scoreboard of expected completions.
// Each step checks the grant and memory drive in the same cycle, then checks the completion on the next cycle.
`default_nettype none

module tb_dm_arb;

    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Req0 = 1'b0, We0 = 1'b0, Lock0 = 1'b0;
    logic [7:0] Adr0 = '0, Wdat0 = '0;
    logic       Req1 = 1'b0, We1 = 1'b0, Lock1 = 1'b0;
    logic [7:0] Adr1 = '0, Wdat1 = '0;
    logic       Gnt0, Ack0, Gnt1, Ack1;
    logic [7:0] Rdat0, Rdat1;
    logic [7:0] MemAdr, DatIn, DatOut;
    logic       ReadEn, WriteEn;

    typedef struct {
        bit         v;
        bit         id;
        bit         rd;
        logic [7:0] data;
    } sb_t;

    sb_t        sb[$];
    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    logic [7:0] exp_rdat0 = '0;
    logic [7:0] exp_rdat1 = '0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    dm_arb #(.AW(8), .DW(8), .LockMax(4)) u_dut (
        .clk(clk), .Reset(Reset),
        .Req0(Req0), .We0(We0), .Lock0(Lock0), .Adr0(Adr0), .Wdat0(Wdat0),
        .Gnt0(Gnt0), .Ack0(Ack0), .Rdat0(Rdat0),
        .Req1(Req1), .We1(We1), .Lock1(Lock1), .Adr1(Adr1), .Wdat1(Wdat1),
        .Gnt1(Gnt1), .Ack1(Ack1), .Rdat1(Rdat1),
        .MemAdr(MemAdr), .ReadEn(ReadEn), .WriteEn(WriteEn),
        .DatIn(DatIn), .DatOut(DatOut)
    );

    // Behavioural single-ported dm: combinational read, write at the clock edge, a known pattern on reset.
    assign DatOut = mem[MemAdr];
    always @(posedge clk) begin
        if (Reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
        end else if (WriteEn) begin
            mem[MemAdr] <= DatIn;
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic rst,
                        input logic r0, input logic w0, input logic l0,
                        input logic [7:0] a0, input logic [7:0] d0,
                        input logic r1, input logic w1, input logic l1,
                        input logic [7:0] a1, input logic [7:0] d1,
                        input int eg);
        sb_t        e;
        logic [7:0] ea, ed;
        logic       ew;
        Reset = rst;
        Req0 = r0; We0 = w0; Lock0 = l0; Adr0 = a0; Wdat0 = d0;
        Req1 = r1; We1 = w1; Lock1 = l1; Adr1 = a1; Wdat1 = d1;
        @(negedge clk);
        e = '{v: 1'b0, id: 1'b0, rd: 1'b0, data: 8'h00};
        if (sb.size() > 0) e = sb.pop_front();
        if (rst) begin
            e.v = 1'b0;
            exp_rdat0 = '0;
            exp_rdat1 = '0;
        end
        chk({tag, ":ack0"}, 16'(Ack0), 16'(e.v && !e.id));
        chk({tag, ":ack1"}, 16'(Ack1), 16'(e.v && e.id));
        if (e.v && e.rd) begin
            if (e.id) exp_rdat1 = e.data;
            else      exp_rdat0 = e.data;
        end
        chk({tag, ":rdat0"}, 16'(Rdat0), 16'(exp_rdat0));
        chk({tag, ":rdat1"}, 16'(Rdat1), 16'(exp_rdat1));
        chk({tag, ":gnt0"}, 16'(Gnt0), 16'(eg == 0));
        chk({tag, ":gnt1"}, 16'(Gnt1), 16'(eg == 1));
        if (eg >= 0) begin
            ea = (eg == 1) ? a1 : a0;
            ed = (eg == 1) ? d1 : d0;
            ew = (eg == 1) ? w1 : w0;
            chk({tag, ":memadr"}, 16'(MemAdr), 16'(ea));
            chk({tag, ":writeen"}, 16'(WriteEn), 16'(ew));
            chk({tag, ":readen"}, 16'(ReadEn), 16'(!ew));
            if (ew) chk({tag, ":datin"}, 16'(DatIn), 16'(ed));
            sb.push_back('{v: 1'b1, id: (eg == 1), rd: !ew, data: ref_mem[ea]});
            if (ew) ref_mem[ea] = ed;
        end else begin
            chk({tag, ":idle_adr"}, 16'(MemAdr), 16'h0);
            chk({tag, ":idle_en"}, {14'h0, WriteEn, ReadEn}, 16'h0);
            chk({tag, ":idle_din"}, 16'(DatIn), 16'h0);
            sb.push_back('{v: 1'b0, id: 1'b0, rd: 1'b0, data: 8'h00});
        end
        if (rst) begin
            for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h5A;

        // Reset with both requesting: nothing is granted and the memory is not driven.
        step("rst_a", 1, 1,0,0,8'h01,8'h00, 1,0,0,8'h02,8'h00, -1);
        step("rst_b", 1, 1,1,0,8'h05,8'h77, 1,1,0,8'h06,8'h88, -1);

        // A write from requester 0, then a read of the same address by requester 1 on the next cycle.
        step("wr0",   0, 1,1,0,8'h10,8'hA5, 0,0,0,8'h00,8'h00, 0);
        step("raw1",  0, 0,0,0,8'h00,8'h00, 1,0,0,8'h10,8'h00, 1);
        chk("dm_write", 16'(mem[8'h10]), 16'h00A5);

        // Both requesting on every cycle: the grant alternates 0,1,0,1.
        step("rr_a",  0, 1,0,0,8'h01,8'h00, 1,0,0,8'h02,8'h00, 0);
        step("rr_b",  0, 1,0,0,8'h01,8'h00, 1,0,0,8'h02,8'h00, 1);
        step("rr_c",  0, 1,0,0,8'h01,8'h00, 1,0,0,8'h02,8'h00, 0);
        step("rr_d",  0, 1,0,0,8'h01,8'h00, 1,0,0,8'h02,8'h00, 1);

        // Lock: 0 keeps ownership and 1 is held off, including one idle owned cycle.
        step("lk_a",  0, 1,0,1,8'h03,8'h00, 1,0,0,8'h04,8'h00, 0);
        step("lk_b",  0, 1,0,1,8'h03,8'h00, 1,0,0,8'h04,8'h00, 0);
        step("lk_c",  0, 1,0,1,8'h03,8'h00, 1,0,0,8'h04,8'h00, 0);
        step("lk_rel",0, 0,0,0,8'h03,8'h00, 1,0,0,8'h04,8'h00, -1);
        step("lk_nxt",0, 1,0,0,8'h03,8'h00, 1,0,0,8'h04,8'h00, 1);

        // Forced break at LockMax=4: four grants to 0, then the pointer favours 1.
        step("brk_1", 0, 1,0,1,8'h07,8'h00, 1,0,0,8'h08,8'h00, 0);
        step("brk_2", 0, 1,0,1,8'h07,8'h00, 1,0,0,8'h08,8'h00, 0);
        step("brk_3", 0, 1,0,1,8'h07,8'h00, 1,0,0,8'h08,8'h00, 0);
        step("brk_4", 0, 1,0,1,8'h07,8'h00, 1,0,0,8'h08,8'h00, 0);
        step("brk_5", 0, 1,0,1,8'h07,8'h00, 1,0,0,8'h08,8'h00, 1);

        // A write by requester 1 must leave Rdat1 unchanged.
        step("wr1",   0, 0,0,0,8'h00,8'h00, 1,1,0,8'h20,8'h3C, 1);
        step("idle",  0, 0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, -1);

        // Reset in the cycle after a read grant discards the read. Afterwards, priority is back to 0.
        step("pre_rst",0, 1,0,0,8'h10,8'h00, 0,0,0,8'h00,8'h00, 0);
        step("mid_rst",1, 1,0,0,8'h01,8'h00, 1,0,0,8'h02,8'h00, -1);
        step("post_rst",0, 1,0,0,8'h01,8'h00, 1,0,0,8'h02,8'h00, 0);
        step("drain", 0, 0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
